// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM state encodings,
// the bubble instruction and the default PC increment.
package fetch_stage_pkg;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_DATA_W  = 32;
  localparam int unsigned FETCH_PC_STEP = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD,
    S_DROP = ST_DROP
  } fetch_state_t;

  // DROP still issues a request: its handshake has to finish before the redirect.
  function automatic logic is_req_state(input fetch_state_t s);
    return (s == S_WAIT) || (s == S_DROP);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Request/ready handshake between the fetch stage (master) and the
// multi-cycle instruction memory (slave).
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and an
// unfrozen cycle with nothing to load presents a bubble to ID.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_instr,
  input  logic              load_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              valid_out
);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      pc_out    <= '0;
      instr_out <= DATA_W'(NOP_INSTR);
      valid_out <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        pc_out    <= load_pc;
        instr_out <= load_instr;
        valid_out <= load_valid;
      end else begin
        pc_out    <= '0;
        instr_out <= DATA_W'(NOP_INSTR);
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ready handshake, one-entry skid buffer
// for data returning under freeze, and branch redirect/flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              ADDR_W   = FETCH_ADDR_W,
  parameter int              DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = FETCH_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  fetch_stage_if.master     imem,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              valid_out
);

  fetch_state_t      state;
  fetch_state_t      state_next;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] drop_addr;

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [DATA_W-1:0] buf_instr;

  logic              buf_capture;
  logic              buf_release;
  logic              drop_capture;

  logic              ifid_load;
  logic [ADDR_W-1:0] ifid_pc;
  logic [DATA_W-1:0] ifid_instr;
  logic              ifid_valid;

  assign pc_inc         = pc + ADDR_W'(PC_STEP);
  assign imem.imem_req  = is_req_state(state);
  assign imem.imem_addr = (state == S_DROP) ? drop_addr : pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A redirect overrides everything but reset; a request that is still open
  // when it arrives is finished in DROP against its original address.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    buf_capture  = 1'b0;
    buf_release  = 1'b0;
    drop_capture = 1'b0;
    ifid_load    = 1'b0;
    ifid_pc      = '0;
    ifid_instr   = DATA_W'(NOP_INSTR);
    ifid_valid   = 1'b0;

    if (branch_taken) begin
      pc_next = branch_addr;
      case (state)
        S_WAIT: begin
          if (imem.imem_ready) begin
            state_next = S_WAIT;
          end else begin
            state_next   = S_DROP;
            drop_capture = 1'b1;
          end
        end
        S_DROP:  state_next = S_DROP;
        default: state_next = S_WAIT;
      endcase
    end else begin
      case (state)
        S_IDLE: state_next = S_WAIT;
        S_WAIT: begin
          if (imem.imem_ready) begin
            pc_next = pc_inc;
            if (freeze) begin
              buf_capture = 1'b1;
              state_next  = S_HOLD;
            end else begin
              ifid_load  = 1'b1;
              ifid_pc    = pc_inc;
              ifid_instr = imem.imem_rdata;
              ifid_valid = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            ifid_load   = 1'b1;
            ifid_pc     = buf_pc;
            ifid_instr  = buf_instr;
            ifid_valid  = buf_valid;
            buf_release = 1'b1;
            state_next  = S_WAIT;
          end
        end
        S_DROP: begin
          if (imem.imem_ready) begin
            state_next = S_WAIT;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      drop_addr <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= DATA_W'(NOP_INSTR);
    end else begin
      pc <= pc_next;
      if (drop_capture) begin
        drop_addr <= pc;
      end
      if (branch_taken) begin
        buf_valid <= 1'b0;
        buf_pc    <= '0;
        buf_instr <= DATA_W'(NOP_INSTR);
      end else if (buf_capture) begin
        buf_valid <= 1'b1;
        buf_pc    <= pc_inc;
        buf_instr <= imem.imem_rdata;
      end else if (buf_release) begin
        buf_valid <= 1'b0;
      end
    end
  end

  fetch_stage_if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (freeze),
    .flush     (branch_taken),
    .load      (ifid_load),
    .load_pc   (ifid_pc),
    .load_instr(ifid_instr),
    .load_valid(ifid_valid),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios followed by random traffic, all checked every cycle
// against a queue-based behavioural model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] STEP     = 32'd4;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem_if ();

  fetch_stage #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(RESET_PC),
    .PC_STEP (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem        (imem_if),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .valid_out   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: "started" = first post-reset cycle passed, skid queue holds data
  // returned under freeze, discard marks a request whose data is unwanted.
  bit          m_started;
  bit          m_discard;
  logic [31:0] m_pc;
  logic [31:0] m_stale;
  logic [31:0] sk_pc[$];
  logic [31:0] sk_instr[$];
  logic [31:0] m_pc_out;
  logic [31:0] m_instr;
  logic        m_valid;

  function automatic bit expReq();
    return m_started && (sk_pc.size() == 0);
  endfunction

  function automatic logic [31:0] expAddr();
    return m_discard ? m_stale : m_pc;
  endfunction

  task automatic modelStep(input bit rst_n, input bit frz, input bit br,
                           input logic [31:0] ba, input bit rdy, input logic [31:0] rd);
    bit loaded;
    bit req_now;
    loaded  = 0;
    req_now = expReq();
    if (!rst_n) begin
      m_started = 0; m_discard = 0; m_pc = RESET_PC; m_stale = 0;
      sk_pc.delete(); sk_instr.delete();
      m_pc_out = 0; m_instr = 0; m_valid = 0;
      return;
    end
    if (br) begin
      if (req_now && !m_discard && !rdy) begin
        m_discard = 1;
        m_stale   = m_pc;
      end
      m_pc = ba;
      sk_pc.delete(); sk_instr.delete();
      m_started = 1;
      m_pc_out = 0; m_instr = 0; m_valid = 0;
      return;
    end
    if (!m_started) begin
      m_started = 1;
    end else if (sk_pc.size() > 0) begin
      if (!frz) begin
        m_pc_out = sk_pc.pop_front();
        m_instr  = sk_instr.pop_front();
        m_valid  = 1;
        loaded   = 1;
      end
    end else if (rdy) begin
      if (m_discard) begin
        m_discard = 0;
      end else begin
        if (frz) begin
          sk_pc.push_back(m_pc + STEP);
          sk_instr.push_back(rd);
        end else begin
          m_pc_out = m_pc + STEP;
          m_instr  = rd;
          m_valid  = 1;
          loaded   = 1;
        end
        m_pc = m_pc + STEP;
      end
    end
    if (!loaded && !frz) begin
      m_pc_out = 0; m_instr = 0; m_valid = 0;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".imem_req"},  {31'd0, imem_if.imem_req}, {31'd0, expReq()});
    checkValue({tag, ".imem_addr"}, imem_if.imem_addr, expAddr());
    checkValue({tag, ".pc_out"},    pc_out, m_pc_out);
    checkValue({tag, ".instr_out"}, instr_out, m_instr);
    checkValue({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, m_valid});
  endtask

  task automatic applyStimulus(input string tag, input bit rst_n, input bit frz, input bit br,
                               input logic [31:0] ba, input bit rdy, input logic [31:0] rd);
    rst                = rst_n;
    freeze             = frz;
    branch_taken       = br;
    branch_addr        = ba;
    imem_if.imem_ready = rdy;
    imem_if.imem_rdata = rd;
    @(posedge clk);
    modelStep(rst_n, frz, br, ba, rdy, rd);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    bit          r_rst;
    bit          r_frz;
    bit          r_br;
    bit          r_rdy;
    logic [31:0] r_ba;

    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_if.imem_ready = 1'b0; imem_if.imem_rdata = '0;
    m_started = 0; m_discard = 0; m_pc = RESET_PC; m_stale = 0;
    m_pc_out = 0; m_instr = 0; m_valid = 0;

    // reset and first fetch
    applyStimulus("reset0", 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 0, 0, 0, 0, 0, 0);
    checkValue("reset.req", {31'd0, imem_if.imem_req}, 32'd0);
    checkValue("reset.valid", {31'd0, valid_out}, 32'd0);
    applyStimulus("idle", 1, 0, 0, 0, 0, 0);
    checkValue("t1.first_addr", imem_if.imem_addr, 32'h0);

    // 1: ready every second cycle
    for (int i = 0; i < 2; i++) begin
      applyStimulus("t1.gap", 1, 0, 0, 0, 0, 0);
      applyStimulus("t1.ready", 1, 0, 0, 0, 1, 32'hE3A01005);
      if (i == 0) begin
        checkValue("t1.pc_out", pc_out, 32'h4);
        checkValue("t1.instr", instr_out, 32'hE3A01005);
        checkValue("t1.valid", {31'd0, valid_out}, 32'd1);
      end
    end
    checkValue("t1.addr8", imem_if.imem_addr, 32'h8);

    // 2: freeze across a ready at pc=8
    applyStimulus("t2.frz0", 1, 1, 0, 0, 0, 0);
    applyStimulus("t2.frz1", 1, 1, 0, 0, 1, 32'h1111_1111);
    checkValue("t2.hold_req", {31'd0, imem_if.imem_req}, 32'd0);
    checkValue("t2.hold_pc_out", pc_out, 32'h8);
    applyStimulus("t2.frz2", 1, 1, 0, 0, 0, 0);
    applyStimulus("t2.release", 1, 0, 0, 0, 0, 0);
    checkValue("t2.buf_pc", pc_out, 32'hC);
    checkValue("t2.buf_instr", instr_out, 32'h1111_1111);
    checkValue("t2.next_addr", imem_if.imem_addr, 32'hC);

    // 3: branch while waiting at pc=0x10
    applyStimulus("t3.fetchC", 1, 0, 0, 0, 1, 32'h2222_0000);
    applyStimulus("t3.branch", 1, 0, 1, 32'h40, 0, 0);
    checkValue("t3.flush_valid", {31'd0, valid_out}, 32'd0);
    checkValue("t3.stale_addr", imem_if.imem_addr, 32'h10);
    applyStimulus("t3.wait", 1, 0, 0, 0, 0, 0);
    applyStimulus("t3.drop_ready", 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkValue("t3.dropped_valid", {31'd0, valid_out}, 32'd0);
    checkValue("t3.redirect_addr", imem_if.imem_addr, 32'h40);

    // 4: branch and freeze together in HOLD
    applyStimulus("t4.to_hold", 1, 1, 0, 0, 1, 32'h3333_3333);
    applyStimulus("t4.branch_frz", 1, 1, 1, 32'h80, 0, 0);
    checkValue("t4.flush_valid", {31'd0, valid_out}, 32'd0);
    applyStimulus("t4.after", 1, 0, 0, 0, 0, 0);
    checkValue("t4.no_buf_valid", {31'd0, valid_out}, 32'd0);
    checkValue("t4.addr", imem_if.imem_addr, 32'h80);

    // 5: PC wrap at the top of the address space
    applyStimulus("t5.branch", 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    applyStimulus("t5.drop_ready", 1, 0, 0, 0, 1, 32'h0BAD_0BAD);
    checkValue("t5.top_addr", imem_if.imem_addr, 32'hFFFF_FFFC);
    applyStimulus("t5.ready", 1, 0, 0, 0, 1, 32'h4444_4444);
    checkValue("t5.wrap_pc_out", pc_out, 32'h0);
    checkValue("t5.wrap_addr", imem_if.imem_addr, 32'h0);

    // 6: reset while in DROP
    applyStimulus("t6.branch", 1, 0, 1, 32'h100, 0, 0);
    applyStimulus("t6.reset", 0, 0, 0, 0, 0, 0);
    checkValue("t6.req", {31'd0, imem_if.imem_req}, 32'd0);
    checkValue("t6.valid", {31'd0, valid_out}, 32'd0);
    applyStimulus("t6.restart", 1, 0, 0, 0, 0, 0);
    checkValue("t6.addr", imem_if.imem_addr, RESET_PC);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 99) >= 2);
      r_frz = ($urandom_range(0, 99) < 30);
      r_br  = ($urandom_range(0, 99) < 10);
      r_rdy = expReq() && ($urandom_range(0, 1) == 1);
      r_ba  = $urandom();
      if ($urandom_range(0, 3) != 0) r_ba[1:0] = 2'b00;
      applyStimulus("rand", r_rst, r_frz, r_br, r_ba, r_rdy, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
